// File: rtl/dsconv_bn_pkg.sv
// Shared default widths and output-stage helpers for the streaming batch-norm stage.
package dsconv_bn_pkg;

    localparam int DEF_DATA_W     = 18;
    localparam int DEF_Q_W        = 36;
    localparam int DEF_FRAC_SHIFT = 9;
    localparam int DEF_CHANNELS   = 16;

    typedef logic signed [DEF_Q_W:0]      acc_t;
    typedef logic signed [DEF_DATA_W-1:0] pix_t;

    localparam acc_t SAT_MAX = acc_t'((64'sd1 <<< (DEF_DATA_W - 1)) - 64'sd1);
    localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);

    // Clamp a shifted accumulator into the signed pixel range.
    function automatic pix_t saturate(input acc_t v);
        if (v > SAT_MAX) begin
            return pix_t'(SAT_MAX);
        end
        if (v < SAT_MIN) begin
            return pix_t'(SAT_MIN);
        end
        return pix_t'(v);
    endfunction

    function automatic pix_t relu(input pix_t v, input logic en);
        return (en && v[DEF_DATA_W-1]) ? '0 : v;
    endfunction

endpackage

// File: rtl/dsconv_bn_mac.sv
// Registered signed multiply-add z = x*p + q with clock enable; sized to map onto one DSP slice.
module dsconv_bn_mac #(
    parameter int DATA_W = 18,
    parameter int Q_W    = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] p,
    input  logic signed [Q_W-1:0]    q,
    output logic signed [Q_W:0]      z
);

    logic signed [Q_W:0] x_ext;
    logic signed [Q_W:0] p_ext;
    logic signed [Q_W:0] q_ext;

    // The full x*p product fits well inside Q_W+1 bits, so the wide multiply is exact.
    assign x_ext = {{(Q_W + 1 - DATA_W){x[DATA_W-1]}}, x};
    assign p_ext = {{(Q_W + 1 - DATA_W){p[DATA_W-1]}}, p};
    assign q_ext = {q[Q_W-1], q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= '0;
        end else if (en) begin
            z <= x_ext * p_ext + q_ext;
        end
    end

endmodule

// File: rtl/dsconv_block_bn_stream.sv
// Streaming per-channel batch-norm: y = sat((x*p + q) >>> FRAC_SHIFT), optional ReLU,
// three-stage valid/ready pipeline with a channel-indexed coefficient RAM.
module dsconv_block_bn_stream
    import dsconv_bn_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int Q_W        = DEF_Q_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [CH_W-1:0]          coef_addr,
    input  logic signed [DATA_W-1:0] coef_p,
    input  logic signed [Q_W-1:0]    coef_q,
    input  logic                     relu_en,
    input  logic                     ch_clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch
);

    logic                     en;
    logic                     accept;
    logic [CH_W-1:0]          ch;

    logic [DATA_W+Q_W-1:0]    coef_mem [CHANNELS];
    logic [DATA_W+Q_W-1:0]    rd_word;

    logic                     s1_valid;
    logic                     s1_last;
    logic [CH_W-1:0]          s1_ch;
    logic signed [DATA_W-1:0] s1_x;
    logic signed [DATA_W-1:0] s1_p;
    logic signed [Q_W-1:0]    s1_q;

    logic                     s2_valid;
    logic                     s2_last;
    logic [CH_W-1:0]          s2_ch;
    logic signed [Q_W:0]      s2_z;

    logic signed [Q_W:0]      s2_shift;
    logic signed [DATA_W-1:0] s3_pix;

    // The whole pipeline moves together; it only freezes when the output is blocked.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
        end else if (ch_clear) begin
            ch <= '0;
        end else if (accept && in_last) begin
            ch <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + CH_W'(1);
        end
    end

    // Read-before-write RAM: a same-address read in the write cycle sees the old entry.
    always_ff @(posedge clk) begin
        if (coef_we) begin
            coef_mem[coef_addr] <= {coef_p, coef_q};
        end
        if (en) begin
            rd_word <= coef_mem[ch];
        end
    end

    assign s1_p = $signed(rd_word[DATA_W+Q_W-1 -: DATA_W]);
    assign s1_q = $signed(rd_word[Q_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_ch    <= '0;
            s1_x     <= '0;
        end else if (en) begin
            s1_valid <= accept;
            s1_last  <= in_last;
            s1_ch    <= ch;
            s1_x     <= in_data;
        end
    end

    dsconv_bn_mac #(
        .DATA_W (DATA_W),
        .Q_W    (Q_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x     (s1_x),
        .p     (s1_p),
        .q     (s1_q),
        .z     (s2_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_ch    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_ch    <= s1_ch;
        end
    end

    always_comb begin
        s2_shift = s2_z >>> FRAC_SHIFT;
        s3_pix   = relu(saturate(s2_shift), relu_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_last  <= s2_last;
            out_ch    <= s2_ch;
            out_data  <= s3_pix;
        end
    end

endmodule

// File: tb/tb_dsconv_block_bn_stream.sv
// Self-checking bench: arithmetic reference model with an expected-beat queue plus
// literal expectations from the hand-worked vectors.
module tb_dsconv_block_bn_stream;

    localparam int DW  = 18;
    localparam int QW  = 36;
    localparam int CHN = 4;
    localparam int CW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 coef_we = 1'b0;
    logic [CW-1:0]        coef_addr = '0;
    logic signed [DW-1:0] coef_p = '0;
    logic signed [QW-1:0] coef_q = '0;
    logic                 relu_en = 1'b0;
    logic                 ch_clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic [CW-1:0]        out_ch;

    typedef struct {
        longint d;
        logic   last;
        int     ch;
        longint acc;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  obs_q[$];
    longint mp[CHN];
    longint mq[CHN];
    int     mch = 0;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     lat_on = 1'b0;
    bit     stall_mode = 1'b0;

    dsconv_block_bn_stream #(
        .DATA_W     (DW),
        .Q_W        (QW),
        .FRAC_SHIFT (9),
        .CHANNELS   (CHN),
        .CH_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_p    (coef_p),
        .coef_q    (coef_q),
        .relu_en   (relu_en),
        .ch_clear  (ch_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: floor((x*p + q) / 512), clamped to 18-bit signed, then optional ReLU.
    function automatic longint bnModel(input longint x, input int c, input bit relu);
        longint z;
        longint s;
        z = x * mp[c] + mq[c];
        s = z / 512;
        if ((z % 512 != 0) && (z < 0)) s = s - 1;
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic writeCoef(input int c, input longint p, input longint q);
        coef_we   = 1'b1;
        coef_addr = CW'(c);
        coef_p    = DW'(p);
        coef_q    = QW'(q);
        @(posedge clk); #1;
        coef_we = 1'b0;
        mp[c] = p;
        mq[c] = q;
    endtask

    task automatic applyStimulus(input longint x, input bit last, input bit clr);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(x);
        in_last  = last;
        ch_clear = clr;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{bnModel(x, mch, relu_en), last, mch, cyc});
                if (clr) mch = 0;
                else if (last) mch = (mch + 1) % CHN;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ch_clear = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic checkObsAt(input string name, input int idx, input longint d, input int c);
        if (idx >= obs_q.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no beat %0d, required data %0d", name, idx, d);
        end else begin
            checkOutput(name, obs_q[idx].d, d);
            checkOutput({name, "_ch"}, obs_q[idx].ch, c);
        end
    endtask

    // Output side: beats are checked at negedge, so values are sampled away from the edge.
    initial begin
        beat_t                e;
        bit                   stalled;
        logic signed [DW-1:0] held_d;
        logic                 held_last;
        logic [CW-1:0]        held_ch;
        stalled   = 1'b0;
        held_d    = '0;
        held_last = 1'b0;
        held_ch   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
                if (stalled) begin
                    checkOutput("stall_valid", out_valid, 1);
                    checkOutput("stall_data", out_data, held_d);
                    checkOutput("stall_last", out_last, held_last);
                    checkOutput("stall_ch", out_ch, held_ch);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got data %0d, required no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", out_data, e.d);
                        checkOutput("out_last", out_last, e.last);
                        checkOutput("out_ch", out_ch, e.ch);
                        // Presented with in_ready high at cycle n, visible three cycles later.
                        if (lat_on) checkOutput("latency", cyc - e.acc, 3);
                        obs_q.push_back('{out_data, out_last, out_ch, cyc});
                    end
                end
                stalled   = out_valid && !out_ready;
                held_d    = out_data;
                held_last = out_last;
                held_ch   = out_ch;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish by 2 ms, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_out_ch", out_ch, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_in_ready", in_ready, 1);

        for (int k = 0; k < CHN; k++) writeCoef(k, 512, 0);

        $display("[TB] identity");
        lat_on = 1'b1;
        applyStimulus(100, 0, 0);
        applyStimulus(-100, 0, 0);
        applyStimulus(0, 0, 0);
        waitIdle();
        checkOutput("ident_count", obs_q.size(), 3);
        checkObsAt("ident0", 0, 100, 0);
        checkObsAt("ident1", 1, -100, 0);
        checkObsAt("ident2", 2, 0, 0);
        obs_q.delete();

        $display("[TB] scale and bias");
        writeCoef(0, 1024, 2560);
        applyStimulus(1000, 0, 0);
        applyStimulus(-3000, 0, 0);
        waitIdle();
        relu_en = 1'b1;
        applyStimulus(-3000, 0, 0);
        applyStimulus(1000, 0, 0);
        waitIdle();
        relu_en = 1'b0;
        checkObsAt("scale_pos", 0, 2005, 0);
        checkObsAt("scale_neg", 1, -5995, 0);
        checkObsAt("scale_relu_neg", 2, 0, 0);
        checkObsAt("scale_relu_pos", 3, 2005, 0);
        obs_q.delete();

        $display("[TB] saturation");
        writeCoef(0, 131071, 0);
        applyStimulus(131071, 0, 0);
        applyStimulus(-131072, 0, 0);
        waitIdle();
        checkObsAt("sat_hi", 0, 131071, 0);
        checkObsAt("sat_lo", 1, -131072, 0);
        obs_q.delete();
        lat_on = 1'b0;

        $display("[TB] channel wrap");
        for (int k = 0; k < CHN; k++) writeCoef(k, 512 * (k + 1), 0);
        for (int pl = 0; pl < 5; pl++) begin
            applyStimulus(10, 0, 0);
            applyStimulus(10, 1, 0);
        end
        // Counter now sits at channel 1; clear it on a last beat, which keeps the old channel.
        applyStimulus(10, 1, 1);
        applyStimulus(10, 0, 0);
        waitIdle();
        checkOutput("wrap_count", obs_q.size(), 12);
        for (int i = 0; i < 10; i++) begin
            checkObsAt("wrap", i, 10 * ((i / 2) % 4 + 1), (i / 2) % 4);
            if (i < obs_q.size()) checkOutput("wrap_last", obs_q[i].last, i % 2);
        end
        checkObsAt("clear_last_beat", 10, 20, 1);
        checkObsAt("clear_next_beat", 11, 10, 0);
        obs_q.delete();

        $display("[TB] backpressure");
        writeCoef(0, 512, 0);
        writeCoef(1, -700, 123456);
        writeCoef(2, 3000, -98765);
        writeCoef(3, 131071, 1073741824);
        stall_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(longint'($urandom_range(0, 262143)) - 131072,
                          $urandom_range(0, 3) == 0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        waitIdle();
        stall_mode = 1'b0;
        @(posedge clk); #1;
        checkOutput("bp_count", obs_q.size(), 200);
        obs_q.delete();

        $display("[TB] reset mid-stream");
        writeCoef(0, 512, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(2, 0, 0);
        applyStimulus(3, 0, 0);
        rst_n = 1'b0;
        exp_q.delete();
        mch = 0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst_quiet", obs_q.size(), 0);
        applyStimulus(7, 0, 0);
        waitIdle();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midrst_count", obs_q.size(), 1);
        checkObsAt("midrst_beat", 0, 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsconv_block_bn_stream.md
# dsconv_block_bn_stream

Multi-channel streaming batch-normalisation stage for the depthwise-separable conv block. It applies per-channel folded coefficients y = (x·p + q) >>> FRAC_SHIFT to a pixel stream. Coefficients come from an internal channel-indexed table, and the channel advances at each plane boundary. The block adds valid/ready handshaking, a 3-stage pipeline, output saturation and optional ReLU. It sits between the depthwise/pointwise convolution output and the next layer's input buffer.

## Interface
- DATA_W, 18, pixel and p width (signed)
- Q_W, 36, q width (signed)
- FRAC_SHIFT, 9, arithmetic right shift applied to x·p+q
- CHANNELS, 16, number of coefficient entries; CH_W = max(1, clog2(CHANNELS))

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- coef_we  in  1  coefficient table write strobe
- coef_addr  in  CH_W  table write address
- coef_p  in  DATA_W  p = γ/√(σ²+ε), signed, Q(FRAC_SHIFT)
- coef_q  in  Q_W  q = β − γ·μ/√(σ²+ε), signed, Q(2·FRAC_SHIFT)
- relu_en  in  1  clamp negative results to 0
- ch_clear  in  1  synchronous reset of the channel counter to 0
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  DATA_W  signed input pixel
- in_last  in  1  last pixel of the current channel plane
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  signed normalised pixel
- out_last  out  1  in_last delayed with its pixel
- out_ch  out  CH_W  channel index of out_data

## Operation
- Coefficient table: CHANNELS × (DATA_W+Q_W) with a synchronous read port and a write port. A write takes effect at the next edge. If a read and a write hit the same address in the same cycle, the read returns the old value. Table contents are not reset.
- Channel counter ch: increments on each accepted beat with in_last=1 and wraps from CHANNELS−1 to 0. ch_clear has priority over the increment.
- Pipeline, advanced by en = !out_valid || out_ready:
  - S1: register x, last and ch; table read at ch.
  - S2: z = x·p + q, computed at Q_W+1 bits signed without overflow.
  - S3: s = z >>> FRAC_SHIFT (floor). Saturate s to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. If relu_en, negative s becomes 0. Register the result into out_data.
- relu_en is sampled at S3.
- in_ready = en. An input beat is accepted when in_valid && in_ready.
- The valid bit travels with each stage. Bubbles do not stall upstream stages unless the output is blocked.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_last=0, out_ch=0, all stage valids=0, ch=0. in_ready is 1 after reset.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+3 when out_ready is held high.
- Throughput: 1 pixel/cycle.
- Backpressure: while out_valid && !out_ready, all stages hold, in_ready=0, and out_data/out_last/out_ch stay stable.
- Reset asserted mid-stream drops all in-flight beats immediately. No output follows until new input arrives.
- Coefficient writes during streaming are legal. A write becomes visible to beats whose S1 read occurs after the write edge.
- ch_clear together with an accepted in_last beat: that beat carries the old ch, and ch becomes 0.

## Structure
- Package dsconv_bn_pkg holds:
  - DATA_W/Q_W/FRAC_SHIFT defaults
  - a saturate function (wide signed to DATA_W)
  - a relu function
- One sub-module, dsconv_bn_mac: a registered signed x·p+q with a clock enable. It maps to a DSP.
- The table is an inferred RAM in the top level.

## Test plan
- Identity: ch0 p=512, q=0, relu_en=0. x = 100, −100, 0 → 100, −100, 0 after 3 cycles, back-to-back.
- Scale/bias: p=1024, q=2560, x=1000 → 2005. x=−3000 with relu_en=1 → 0; with relu_en=0 → −5995.
- Saturation: p=131071, q=0. x=131071 → 131071; x=−131072 → −131072.
- Channel wrap with CHANNELS=4: load p_k = 512·(k+1). Send 5 planes of 2 pixels of x=10, in_last on the 2nd pixel of each plane → outputs 10,10,20,20,30,30,40,40,10,10 with out_ch 0,0,1,1,2,2,3,3,0,0.
- Backpressure: random out_ready at 50% over 200 beats → output sequence identical to the no-stall run, no beat lost or duplicated, and out_data stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 immediately. After release, a new beat x=7 with p=512 → single output 7, out_ch=0.
